seg_display_arbiter: RTL and testbench
======================================

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, range 1-255: minimum number of enabled cycles a granted requester owns the display.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  enable; when low, all state, counters and outputs hold their values.
REQ-005 req  input  3  per-requester display request, level-sensitive; bit i belongs to requester i.
REQ-006 digit0, digit1, digit2  input  4 each  value that requester 0/1/2 wants shown.
REQ-007 gnt  output  3  one-hot grant (or 000), registered.
REQ-008 seg  output  8  segment drive to the display, registered; bit 7 down to bit 0 in the team's standard segment order.
REQ-009 busy  output  1  high whenever a grant is active, registered.
REQ-010 owner  output  2  index of the current or most recent grantee, registered.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (no grant) and SHOW (one grant active).
REQ-012 In IDLE with ena=1 and req!=000, the next edge SHALL enter SHOW, set gnt to the round-robin winner, latch that requester's digit, and load hold counter = HOLD_CYCLES-1.
REQ-013 Round-robin order SHALL start at the requester after the last grantee (last+1, last+2, last, modulo 3); after reset, last=2, so requester 0 has highest priority.
REQ-014 In SHOW, each ena=1 edge with counter>0 SHALL decrement the counter; gnt, owner and the latched digit are unchanged.
REQ-015 At an edge in SHOW with counter==0: if another requester has req=1, the FSM SHALL grant it by round-robin (direct SHOW-to-SHOW handover, no IDLE cycle) and reload the counter.
REQ-016 At an edge in SHOW with counter==0 where only the owner requests, the FSM SHALL stay in SHOW, keep the grant, keep the counter at 0, and re-latch the owner's digit.
REQ-017 At an edge in SHOW with counter==0 where req==000, the FSM SHALL return to IDLE with gnt=000 and busy=0.
REQ-018 An owner that drops req before its counter expires SHALL keep gnt and the display until expiry (the minimum hold is guaranteed).
REQ-019 The digit is sampled only on grant edges (REQ-012, REQ-015, REQ-016); changes at other times SHALL be ignored.
REQ-020 seg encoding in SHOW: 0=11111101, 1=11000001, 2=01101111, 3=11100111, 4=11010011, 5=10110111, 6=10111111, 7=11100001, 8=11111111, 9=11110111; digits 10-15 SHALL produce 00000000 (blank).
REQ-021 In IDLE, seg SHALL be 00000010 (dash); owner SHALL retain its last value.
REQ-022 Latency: a req that rises before edge N (FSM in IDLE) SHALL produce gnt, busy and seg updated immediately after edge N.
REQ-023 gnt SHALL never have more than one bit set; busy SHALL equal |gnt at all times.
REQ-024 With ena=0, req changes SHALL be ignored and the counter SHALL not advance.

Reset
REQ-025 While rst_n=0: gnt=000, busy=0, owner=00, seg=00000010, state=IDLE, counter=0, last grantee=2.
REQ-026 Reset asserted mid-SHOW SHALL clear everything immediately, without waiting for clk; the first grant after release follows REQ-013.

Verification (HOLD_CYCLES=4, ena=1 unless stated)
REQ-027 After reset, req=001 and digit0=3 -> after the next edge, gnt=001, busy=1, seg=11100111; the grant holds for 4 edges.
REQ-028 req=111 held constant -> grants 001,010,100,001, each lasting exactly 4 cycles, with no IDLE gap between them.
REQ-029 req=010 pulsed for 1 cycle, digit1=7 -> gnt=010 and seg=11100001 for 4 cycles, then gnt=000 and seg=00000010.
REQ-030 Owner 0 is sole requester past expiry, and digit0 changes 2 to 9 -> seg tracks the change on the next edge (01101111 to 11110111); gnt stays 001.
REQ-031 ena=0 for 5 cycles mid-SHOW -> all outputs frozen; the remaining hold resumes after ena=1; digit0=12 granted -> seg=00000000.
REQ-032 rst_n pulsed low between clock edges during SHOW -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_arbiter_if
// Description : Request/digit/grant/segment bundle shared by the three
//               display requesters (master) and the arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_display_arbiter_if;
    logic       ena;
    logic [2:0] req;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [2:0] gnt;
    logic [7:0] seg;
    logic       busy;
    logic [1:0] owner;

    modport master (
        output ena, req, digit0, digit1, digit2,
        input  gnt, seg, busy, owner
    );

    modport slave (
        input  ena, req, digit0, digit1, digit2,
        output gnt, seg, busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_arbiter
// Description : Round-robin arbiter granting one of three requesters the
//               seven-segment display for a guaranteed minimum hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    seg_display_arbiter_if.slave   bus
);

    localparam logic [7:0] C_SEG_DASH = 8'b0000_0010;
    localparam logic [7:0] C_HOLD_RLD = 8'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_counter;
    logic [1:0] r_last;
    logic [2:0] r_gnt;
    logic [7:0] r_seg;
    logic       r_busy;
    logic [1:0] r_owner;

    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic       w_other_valid;
    logic [1:0] w_other_idx;
    logic       w_self_req;
    logic       w_do_grant;
    logic [1:0] w_grant_idx;

    function automatic logic [7:0] f_encode(input logic [3:0] d);
        case (d)
            4'd0:    f_encode = 8'b1111_1101;
            4'd1:    f_encode = 8'b1100_0001;
            4'd2:    f_encode = 8'b0110_1111;
            4'd3:    f_encode = 8'b1110_0111;
            4'd4:    f_encode = 8'b1101_0011;
            4'd5:    f_encode = 8'b1011_0111;
            4'd6:    f_encode = 8'b1011_1111;
            4'd7:    f_encode = 8'b1110_0001;
            4'd8:    f_encode = 8'b1111_1111;
            4'd9:    f_encode = 8'b1111_0111;
            default: f_encode = 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [1:0] f_next(input logic [1:0] i);
        f_next = (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [3:0] f_digit(input logic [1:0] i,
                                           input logic [3:0] d0,
                                           input logic [3:0] d1,
                                           input logic [3:0] d2);
        case (i)
            2'd0:    f_digit = d0;
            2'd1:    f_digit = d1;
            default: f_digit = d2;
        endcase
    endfunction

    // Round-robin candidate search; r_last equals the owner while in SHOW,
    // so the "other" candidates are always the two non-owner requesters.
    always_comb begin
        w_cand1       = f_next(r_last);
        w_cand2       = f_next(w_cand1);
        w_other_valid = 1'b0;
        w_other_idx   = w_cand1;
        if (bus.req[w_cand1]) begin
            w_other_valid = 1'b1;
            w_other_idx   = w_cand1;
        end else if (bus.req[w_cand2]) begin
            w_other_valid = 1'b1;
            w_other_idx   = w_cand2;
        end
        w_self_req  = bus.req[r_last];
        w_do_grant  = 1'b0;
        w_grant_idx = w_other_idx;
        if (r_state == IDLE) begin
            w_do_grant  = w_other_valid || w_self_req;
            w_grant_idx = w_other_valid ? w_other_idx : r_last;
        end else if (r_counter == 8'd0) begin
            w_do_grant  = w_other_valid;
            w_grant_idx = w_other_idx;
        end
    end

    // Arbitration FSM with registered grant, segment and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_counter <= 8'd0;
            r_last    <= 2'd2;
            r_gnt     <= 3'b000;
            r_seg     <= C_SEG_DASH;
            r_busy    <= 1'b0;
            r_owner   <= 2'd0;
        end else if (bus.ena) begin
            if (w_do_grant) begin
                r_state   <= SHOW;
                r_gnt     <= 3'(3'b001 << w_grant_idx);
                r_owner   <= w_grant_idx;
                r_last    <= w_grant_idx;
                r_busy    <= 1'b1;
                r_seg     <= f_encode(f_digit(w_grant_idx, bus.digit0,
                                              bus.digit1, bus.digit2));
                r_counter <= C_HOLD_RLD;
            end else if (r_state == SHOW) begin
                if (r_counter != 8'd0) begin
                    r_counter <= r_counter - 8'd1;
                end else if (w_self_req) begin
                    // Sole requester past expiry keeps the display and
                    // refreshes its digit every cycle.
                    r_seg <= f_encode(f_digit(r_owner, bus.digit0,
                                              bus.digit1, bus.digit2));
                end else begin
                    r_state <= IDLE;
                    r_gnt   <= 3'b000;
                    r_busy  <= 1'b0;
                    r_seg   <= C_SEG_DASH;
                end
            end
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.seg   = r_seg;
    assign bus.busy  = r_busy;
    assign bus.owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_arbiter
// Description : Directed bench for seg_display_arbiter with a behavioural
//               reference model compared on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    bit   cmp_en;

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the display, how many extra cycles remain,
    // and which digit was captured.
    bit       m_busy;
    int       m_owner;
    int       m_last;
    int       m_rem;
    int       m_digit;
    logic [7:0] seg_tab [16];

    initial begin
        seg_tab[0]  = 8'b1111_1101; seg_tab[1]  = 8'b1100_0001;
        seg_tab[2]  = 8'b0110_1111; seg_tab[3]  = 8'b1110_0111;
        seg_tab[4]  = 8'b1101_0011; seg_tab[5]  = 8'b1011_0111;
        seg_tab[6]  = 8'b1011_1111; seg_tab[7]  = 8'b1110_0001;
        seg_tab[8]  = 8'b1111_1111; seg_tab[9]  = 8'b1111_0111;
        for (int i = 10; i < 16; i++) seg_tab[i] = 8'b0000_0000;
    end

    function automatic int dig_of(int i);
        if (i == 0) return int'(bus.digit0);
        if (i == 1) return int'(bus.digit1);
        return int'(bus.digit2);
    endfunction

    // Model update on each rising edge (or immediately on reset).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_last = 2; m_rem = 0; m_digit = 0;
        end else if (bus.ena) begin
            int  win;
            win = -1;
            if (!m_busy) begin
                for (int k = 1; k <= 3; k++)
                    if (win < 0 && bus.req[(m_last + k) % 3]) win = (m_last + k) % 3;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end else begin
                for (int k = 1; k <= 2; k++)
                    if (win < 0 && bus.req[(m_owner + k) % 3]) win = (m_owner + k) % 3;
                if (win < 0) begin
                    if (bus.req[m_owner]) m_digit = dig_of(m_owner);
                    else                  m_busy = 0;
                end
            end
            if (win >= 0) begin
                m_busy = 1; m_owner = win; m_last = win; m_rem = 3;
                m_digit = dig_of(win);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%b required=%b at t=%0t", name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [7:0] eg, es;
            eg = m_busy ? 8'(1 << m_owner) : 8'd0;
            es = m_busy ? seg_tab[m_digit] : 8'b0000_0010;
            check("model_gnt",   {5'd0, bus.gnt},   eg);
            check("model_seg",   bus.seg,           es);
            check("model_busy",  {7'd0, bus.busy},  {7'd0, m_busy});
            check("model_owner", {6'd0, bus.owner}, 8'(m_owner));
            check("busy_eq_or",  {7'd0, bus.busy},  {7'd0, |bus.gnt});
        end
    end

    initial begin
        n_total = 0; n_pass = 0; cmp_en = 0;
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.req = 3'b000;
        bus.digit0 = 4'd0; bus.digit1 = 4'd0; bus.digit2 = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_gnt",   {5'd0, bus.gnt},  8'd0);
        check("rst_busy",  {7'd0, bus.busy}, 8'd0);
        check("rst_owner", {6'd0, bus.owner}, 8'd0);
        check("rst_seg",   bus.seg, 8'b0000_0010);
        rst_n = 1'b1;
        cmp_en = 1;

        // Single requester, digit 3, hold then release.
        @(negedge clk); bus.req = 3'b001; bus.digit0 = 4'd3;
        @(negedge clk); bus.req = 3'b000;
        check("first_gnt",  {5'd0, bus.gnt}, 8'b0000_0001);
        check("first_busy", {7'd0, bus.busy}, 8'd1);
        check("first_seg",  bus.seg, 8'b1110_0111);
        repeat (3) @(negedge clk);
        check("hold4_gnt", {5'd0, bus.gnt}, 8'b0000_0001);
        @(negedge clk);
        check("expire_gnt", {5'd0, bus.gnt}, 8'd0);
        check("expire_seg", bus.seg, 8'b0000_0010);

        // All three requesting: rotation starts after last grantee 0.
        bus.req = 3'b111; bus.digit1 = 4'd1; bus.digit2 = 4'd8;
        @(negedge clk);
        check("rr_first", {5'd0, bus.gnt}, 8'b0000_0010);
        repeat (4) @(negedge clk);
        check("rr_second", {5'd0, bus.gnt}, 8'b0000_0100);
        repeat (4) @(negedge clk);
        check("rr_third", {5'd0, bus.gnt}, 8'b0000_0001);
        repeat (7) @(negedge clk);
        bus.req = 3'b000;
        repeat (6) @(negedge clk);
        check("rr_idle", {7'd0, bus.busy}, 8'd0);

        // One-cycle pulse from requester 1 still gets the full hold.
        bus.req = 3'b010; bus.digit1 = 4'd7;
        @(negedge clk); bus.req = 3'b000;
        check("pulse_gnt", {5'd0, bus.gnt}, 8'b0000_0010);
        check("pulse_seg", bus.seg, 8'b1110_0001);
        repeat (3) @(negedge clk);
        check("pulse_hold", {5'd0, bus.gnt}, 8'b0000_0010);
        @(negedge clk);
        check("pulse_end_gnt", {5'd0, bus.gnt}, 8'd0);
        check("pulse_end_seg", bus.seg, 8'b0000_0010);

        // Sole owner past expiry re-latches its digit.
        bus.req = 3'b001; bus.digit0 = 4'd2;
        repeat (5) @(negedge clk);
        check("sole_seg2", bus.seg, 8'b0110_1111);
        bus.digit0 = 4'd9;
        @(negedge clk);
        check("sole_seg9", bus.seg, 8'b1111_0111);
        check("sole_gnt",  {5'd0, bus.gnt}, 8'b0000_0001);
        bus.req = 3'b000;
        @(negedge clk);
        check("sole_idle", {7'd0, bus.busy}, 8'd0);

        // Blank digit, then freeze with ena low mid-hold.
        bus.req = 3'b001; bus.digit0 = 4'd12;
        @(negedge clk);
        check("blank_seg", bus.seg, 8'b0000_0000);
        bus.req = 3'b000;
        @(negedge clk);
        bus.ena = 1'b0; bus.req = 3'b110; bus.digit0 = 4'd5;
        repeat (5) @(negedge clk);
        check("frz_gnt",  {5'd0, bus.gnt}, 8'b0000_0001);
        check("frz_seg",  bus.seg, 8'b0000_0000);
        bus.ena = 1'b1; bus.req = 3'b000;
        repeat (2) @(negedge clk);
        check("resume_gnt", {5'd0, bus.gnt}, 8'b0000_0001);
        @(negedge clk);
        check("resume_end", {5'd0, bus.gnt}, 8'd0);

        // Asynchronous reset between edges during SHOW.
        bus.req = 3'b111;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt",   {5'd0, bus.gnt},  8'd0);
        check("arst_busy",  {7'd0, bus.busy}, 8'd0);
        check("arst_owner", {6'd0, bus.owner}, 8'd0);
        check("arst_seg",   bus.seg, 8'b0000_0010);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_gnt", {5'd0, bus.gnt}, 8'b0000_0001);
        bus.req = 3'b000;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
